scan_chain_loader: RTL and testbench



---
 rtl/scan_chain_loader.sv | 159 +++++++++++++++
 tb/tb_scan_chain_loader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/scan_chain_loader.sv
// Serialises host configuration words onto an SRL scan chain, gating CE so exactly
// CHAIN_LEN bits shift per load. Define SCAN_READBACK_EN to capture SOUT for readback.
module scan_chain_loader #(
    parameter int CHAIN_LEN = 992,
    parameter int WORD_W    = 32,
    parameter int CNT_W     = 10
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic [WORD_W-1:0] DIN,
    input  logic              DIN_VALID,
    output logic              DIN_READY,
    output logic              CE,
    output logic              SIN,
    input  logic              SOUT,
    output logic              BUSY,
    output logic              DONE,
    output logic [CNT_W-1:0]  BIT_CNT
`ifdef SCAN_READBACK_EN
    ,
    output logic [WORD_W-1:0] RB_DATA,
    output logic              RB_VALID
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT_WORD, SHIFT, FINISH} state_t;

    localparam int                WB_W      = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [WB_W-1:0]   LAST_WBIT = WB_W'(WORD_W - 1);

    state_t            state_q, state_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WB_W-1:0]   wbit_q, wbit_d;
    logic              ce_q, ce_d;
    logic              sin_q, sin_d;
    logic              din_ready_q, din_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              chain_end, word_end;

    // Words start on word boundaries, so the chain end also ends the (partial) last word.
    assign chain_end = (bit_cnt_q == LAST_BIT);
    assign word_end  = (wbit_q == LAST_WBIT) || chain_end;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            sreg_q      <= '0;
            bit_cnt_q   <= '0;
            wbit_q      <= '0;
            ce_q        <= 1'b0;
            sin_q       <= 1'b0;
            din_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            bit_cnt_q   <= bit_cnt_d;
            wbit_q      <= wbit_d;
            ce_q        <= ce_d;
            sin_q       <= sin_d;
            din_ready_q <= din_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (START) state_d = WAIT_WORD;
            WAIT_WORD: if (DIN_VALID) state_d = SHIFT;
            SHIFT:     if (word_end) state_d = chain_end ? FINISH : WAIT_WORD;
            FINISH:    state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        sreg_d    = sreg_q;
        bit_cnt_d = bit_cnt_q;
        wbit_d    = wbit_q;
        case (state_q)
            IDLE: if (START) bit_cnt_d = '0;
            WAIT_WORD: begin
                if (DIN_VALID) begin
                    sreg_d = DIN;
                    wbit_d = '0;
                end
            end
            SHIFT: begin
                sreg_d    = sreg_q >> 1;
                bit_cnt_d = bit_cnt_q + 1'b1;
                wbit_d    = wbit_q + 1'b1;
            end
            default: ;
        endcase
    end

    // Outputs are decoded from the next state so every port comes straight off a flop.
    always_comb begin
        din_ready_d = (state_d == WAIT_WORD);
        ce_d        = (state_d == SHIFT);
        sin_d       = ce_d & sreg_d[0];
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == FINISH);
    end

    assign DIN_READY = din_ready_q;
    assign CE        = ce_q;
    assign SIN       = sin_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign BIT_CNT   = bit_cnt_q;

`ifdef SCAN_READBACK_EN
    logic [WORD_W-1:0] cap_q, cap_d;
    logic [WORD_W-1:0] rb_data_q, rb_data_d;
    logic              rb_valid_q, rb_valid_d;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cap_q      <= '0;
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            cap_q      <= cap_d;
            rb_data_q  <= rb_data_d;
            rb_valid_q <= rb_valid_d;
        end
    end

    // SOUT is sampled on the same edges that shift the chain, so it sees the old contents.
    always_comb begin
        cap_d      = cap_q;
        rb_data_d  = rb_data_q;
        rb_valid_d = 1'b0;
        if (state_q == WAIT_WORD && DIN_VALID) cap_d = '0;
        if (state_q == SHIFT) begin
            cap_d[wbit_q] = SOUT;
            if (word_end) begin
                rb_data_d  = cap_d;
                rb_valid_d = 1'b1;
            end
        end
    end

    assign RB_DATA  = rb_data_q;
    assign RB_VALID = rb_valid_q;
`else
    logic sout_unused;
    assign sout_unused = SOUT;
`endif

endmodule

// File: tb/tb_scan_chain_loader.sv
// Directed bench for scan_chain_loader: chain model on CE/SIN/SOUT, scoreboard queues
// for SIN bits, CE run lengths and (with SCAN_READBACK_EN) readback words.
module tb_scan_chain_loader;
    localparam int CL = 40;
    localparam int WW = 32;
    localparam int CW = 6;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          START = 1'b0;
    logic [WW-1:0] DIN = '0;
    logic          DIN_VALID = 1'b0;
    logic          DIN_READY, CE, SIN, SOUT, BUSY, DONE;
    logic [CW-1:0] BIT_CNT;
`ifdef SCAN_READBACK_EN
    logic [WW-1:0] RB_DATA;
    logic          RB_VALID;
`endif

    int n_cmp = 0;
    int n_fail = 0;
    int ncyc = 0, ce_run = 0, ce_total = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0;

    logic [CL-1:0] chain = '0;
    logic          sin_q[$];
    int            run_q[$];
    logic [WW-1:0] rb_q[$];

    always #5 CLK = ~CLK;

    // Chain model: new bits enter at [0], SOUT is the far end.
    assign SOUT = chain[CL-1];
    always @(posedge CLK) if (CE === 1'b1) chain <= {chain[CL-2:0], SIN};

    scan_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW), .CNT_W(CW)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .DIN(DIN), .DIN_VALID(DIN_VALID),
        .DIN_READY(DIN_READY), .CE(CE), .SIN(SIN), .SOUT(SOUT), .BUSY(BUSY),
        .DONE(DONE), .BIT_CNT(BIT_CNT)
`ifdef SCAN_READBACK_EN
        , .RB_DATA(RB_DATA), .RB_VALID(RB_VALID)
`endif
    );

    function automatic void check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endfunction

    always @(negedge CLK) begin
        ncyc++;
        if (DONE === 1'b1) begin
            done_cnt++;
            done_cyc = ncyc;
        end
        if (CE === 1'b1) begin
            ce_run++;
            ce_total++;
            if (sin_q.size() == 0) check("ce_unexpected", CE, 0);
            else check("sin", SIN, sin_q.pop_front());
        end else if (ce_run != 0) begin
            if (run_q.size() != 0) check("ce_run_len", ce_run, run_q.pop_front());
            ce_run = 0;
        end
`ifdef SCAN_READBACK_EN
        if (RB_VALID === 1'b1) begin
            if (rb_q.size() == 0) check("rb_unexpected", RB_VALID, 0);
            else check("rb_data", RB_DATA, rb_q.pop_front());
        end
`endif
    end

    task automatic send(input logic [WW-1:0] w, input int k, input int stall);
        int cyc = 0;
        while (DIN_READY !== 1'b1 && cyc < 200) begin
            @(negedge CLK);
            cyc++;
        end
        if (cyc >= 200) check("ready_timeout", DIN_READY, 1);
        for (int i = 0; i < stall; i++) begin
            @(negedge CLK);
            check("stall_ce", CE, 0);
        end
        DIN = w;
        DIN_VALID = 1'b1;
        for (int i = 0; i < k; i++) sin_q.push_back(w[i]);
        run_q.push_back(k);
        @(posedge CLK);
        #1;
        DIN_VALID = 1'b0;
        DIN = '0;
    endtask

    task automatic load(input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                        input int stall, input bit poke, input int exp_lat);
        logic [CL-1:0] s, e, p;
        int d0, ce0, cyc;
        s = {w1[CL-WW-1:0], w0};
        for (int i = 0; i < CL; i++) begin
            e[CL-1-i] = s[i];
            p[i] = chain[CL-1-i];
        end
`ifdef SCAN_READBACK_EN
        rb_q.push_back(p[WW-1:0]);
        rb_q.push_back(WW'(p[CL-1:WW]));
`endif
        d0 = done_cnt;
        ce0 = ce_total;
        @(posedge CLK);
        #1;
        START = 1'b1;
        start_cyc = ncyc + 1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        @(negedge CLK);
        check("ready_after_start", DIN_READY, 1);
        check("busy_in_load", BUSY, 1);
        send(w0, WW, 0);
        if (poke) begin
            @(posedge CLK);
            #1;
            START = 1'b1;
            @(posedge CLK);
            #1;
            START = 1'b0;
        end
        send(w1, CL - WW, stall);
        cyc = 0;
        while (done_cnt == d0 && cyc < 300) begin
            @(posedge CLK);
            #1;
            cyc++;
        end
        check("done_latency", done_cyc - start_cyc, exp_lat);
        repeat (3) @(posedge CLK);
        #1;
        check("done_pulses", done_cnt - d0, 1);
        check("bit_cnt_final", BIT_CNT, CL);
        check("busy_after", BUSY, 0);
        check("ce_total", ce_total - ce0, CL);
        check("chain_contents", chain, e);
        check("sin_q_drained", sin_q.size(), 0);
        check("rb_q_drained", rb_q.size(), 0);
    endtask

    initial begin
        RST_N = 1'b0;
        START = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_ce", CE, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_bit_cnt", BIT_CNT, 0);
        check("rst_din_ready", DIN_READY, 0);
        check("rst_sin", SIN, 0);
        START = 1'b0;
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        check("idle_busy", BUSY, 0);

        load(32'hA5A5_0F0F, 32'h0000_00C3, 0, 1'b0, 43);
        load(32'hA5A5_0F0F, 32'h0000_00C3, 5, 1'b0, 48);
        load(32'h1234_5678, 32'hFFFF_FF5A, 0, 1'b1, 43);

        // Abort a load after 17 shift cycles.
        @(posedge CLK);
        #1;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        send(32'hDEAD_BEEF, WW, 0);
        repeat (16) @(posedge CLK);
        #1;
        RST_N = 1'b0;
        @(posedge CLK);
        #1;
        sin_q.delete();
        run_q.delete();
        rb_q.delete();
        check("abort_ce", CE, 0);
        check("abort_busy", BUSY, 0);
        check("abort_bit_cnt", BIT_CNT, 0);
        check("abort_sin", SIN, 0);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        load(32'hA5A5_0F0F, 32'h0000_00C3, 0, 1'b0, 43);
        load(32'h0F1E_2D3C, 32'h0000_0081, 0, 1'b0, 43);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
